spi_flash_reader: RTL

//  SPI mode-0 master that reads serial NOR flash (M25P-compatible command set) and streams bytes out.

---
 rtl/spi_flash_reader_if.sv | 24 ++
 rtl/spi_flash_reader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reader_if.sv
// Request/response stream bundle between the fabric and spi_flash_reader.
// The master side issues {addr, len} requests and consumes the returned data bytes.
interface spi_flash_reader_if #(
  parameter int LEN_WIDTH = 16
) ();
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [23:0]          cmd_addr;
  logic [LEN_WIDTH-1:0] cmd_len;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [7:0]           rsp_data;
  logic                 rsp_last;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_last
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_last
  );
endinterface

// File: rtl/spi_flash_reader.sv
// SPI mode-0 master reading M25P-style NOR flash and streaming the bytes on a valid/ready bus.
// Define SPI_FAST_READ_EN to issue FAST_READ (0x0B) with 8 dummy clocks instead of READ (0x03).
module spi_flash_reader #(
  parameter int CLK_DIV   = 2,
  parameter int LEN_WIDTH = 16
) (
  input  logic              io_clock,
  input  logic              io_reset,
  spi_flash_reader_if.slave bus,
  output logic              busy,
  output logic              io_spi_sclk,
  output logic              io_spi_ss,
  output logic              io_spi_mosi,
  input  logic              io_spi_miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] OPCODE = 8'h0B;
`else
  localparam logic [7:0] OPCODE = 8'h03;
`endif

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    CMD,
    ADDR,
`ifdef SPI_FAST_READ_EN
    DUMMY,
`endif
    DATA,
    DESEL
  } state_t;

`ifdef SPI_FAST_READ_EN
  localparam state_t AFTER_ADDR = DUMMY;
`else
  localparam state_t AFTER_ADDR = DATA;
`endif

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [4:0]           bit_q, bit_d;
  logic [30:0]          tx_q, tx_d;
  logic [6:0]           rx_q, rx_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic                 sclk_q, sclk_d;
  logic                 ss_q, ss_d;
  logic                 mosi_q, mosi_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [7:0]           rsp_data_q, rsp_data_d;
  logic                 rsp_last_q, rsp_last_d;
  logic                 tick;
  logic                 stall;
  logic                 cmd_ready;

  assign cmd_ready = (state_q == IDLE) && !rsp_valid_q;

  // A finished byte may only land in the output register once the previous one has left it,
  // so the 8th rising edge is withheld while the consumer is still holding off.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rem_d       = rem_q;
    sclk_d      = sclk_q;
    ss_d        = ss_q;
    mosi_d      = mosi_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
    tick        = (div_q == DIV_W'(CLK_DIV - 1));
    stall       = (state_q == DATA) && (bit_q == 5'd7) && !sclk_q &&
                  rsp_valid_q && !bus.rsp_ready;

    if (state_q != IDLE) div_d = tick ? '0 : div_q + DIV_W'(1);
    if (rsp_valid_q && bus.rsp_ready) rsp_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready && (bus.cmd_len != '0)) begin
          state_d = SEL;
          ss_d    = 1'b0;
          mosi_d  = OPCODE[7];
          tx_d    = {OPCODE[6:0], bus.cmd_addr};
          rem_d   = bus.cmd_len;
          bit_d   = '0;
          div_d   = '0;
        end
      end
      SEL: begin
        if (tick) state_d = CMD;
      end
      CMD, ADDR
`ifdef SPI_FAST_READ_EN
      , DUMMY
`endif
      : begin
        if (tick) begin
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            mosi_d = tx_q[30];
            tx_d   = {tx_q[29:0], 1'b0};
            bit_d  = bit_q + 5'd1;
            if (state_q == CMD && bit_q == 5'd7) begin
              state_d = ADDR;
              bit_d   = '0;
            end else if (state_q == ADDR && bit_q == 5'd23) begin
              state_d = AFTER_ADDR;
              bit_d   = '0;
            end
`ifdef SPI_FAST_READ_EN
            else if (state_q == DUMMY && bit_q == 5'd7) begin
              state_d = DATA;
              bit_d   = '0;
            end
`endif
          end
        end
      end
      DATA: begin
        if (tick && !stall) begin
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            if (bit_q == 5'd7) begin
              rsp_data_d  = {rx_q, io_spi_miso};
              rsp_valid_d = 1'b1;
              rsp_last_d  = (rem_q == LEN_WIDTH'(1));
              rem_d       = rem_q - LEN_WIDTH'(1);
              bit_d       = '0;
            end else begin
              rx_d  = {rx_q[5:0], io_spi_miso};
              bit_d = bit_q + 5'd1;
            end
          end else if (rem_q == '0) begin
            state_d = DESEL;
          end
        end
      end
      // SS stays low for one half-period after the last falling edge, then high for two.
      DESEL: begin
        if (tick) begin
          if (bit_q == 5'd0) ss_d = 1'b1;
          if (bit_q == 5'd2) state_d = IDLE;
          else bit_d = bit_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge io_clock or posedge io_reset) begin
    if (io_reset) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rem_q       <= '0;
      sclk_q      <= 1'b0;
      ss_q        <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rem_q       <= rem_d;
      sclk_q      <= sclk_d;
      ss_q        <= ss_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_last  = rsp_last_q;
  assign busy          = (state_q != IDLE);
  assign io_spi_sclk   = sclk_q;
  assign io_spi_ss     = ss_q;
  assign io_spi_mosi   = mosi_q;

endmodule
